// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the I/D memory bus arbiter: bus command encodings,
// client identifiers and the tag owner table entry.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_cmd_t;

   typedef enum logic {
      IC = 1'b0,
      DC = 1'b1
   } client_t;

   typedef struct packed {
      logic vld;
      logic is_dc;
   } owner_ent_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Client request/grant/return signals and the unified memory port, bundled
// for the arbiter; slave is the arbiter side, master the environment side.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int TAG_W  = 4
);

   logic              ic_req_vld;
   logic [ADDR_W-1:0] ic_req_addr;
   logic              ic_gnt;
   logic [TAG_W-1:0]  ic_gnt_tag;
   logic              ic_data_vld;
   logic [TAG_W-1:0]  ic_data_tag;
   logic [DATA_W-1:0] ic_data;

   logic              dc_req_vld;
   logic              dc_req_st;
   logic [ADDR_W-1:0] dc_req_addr;
   logic [DATA_W-1:0] dc_req_data;
   logic              dc_gnt;
   logic [TAG_W-1:0]  dc_gnt_tag;
   logic              dc_data_vld;
   logic [TAG_W-1:0]  dc_data_tag;
   logic [DATA_W-1:0] dc_data;

   logic [1:0]        proc2mem_command;
   logic [ADDR_W-1:0] proc2mem_addr;
   logic [DATA_W-1:0] proc2mem_data;
   logic [TAG_W-1:0]  mem2proc_response;
   logic [DATA_W-1:0] mem2proc_data;
   logic [TAG_W-1:0]  mem2proc_tag;

   logic              arb_err;

   modport slave (
      input  ic_req_vld, ic_req_addr,
      output ic_gnt, ic_gnt_tag, ic_data_vld, ic_data_tag, ic_data,
      input  dc_req_vld, dc_req_st, dc_req_addr, dc_req_data,
      output dc_gnt, dc_gnt_tag, dc_data_vld, dc_data_tag, dc_data,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output arb_err
   );

   modport master (
      output ic_req_vld, ic_req_addr,
      input  ic_gnt, ic_gnt_tag, ic_data_vld, ic_data_tag, ic_data,
      output dc_req_vld, dc_req_st, dc_req_addr, dc_req_data,
      input  dc_gnt, dc_gnt_tag, dc_data_vld, dc_data_tag, dc_data,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  arb_err
   );

endinterface

// File: rtl/mem_bus_arbiter_owner_table.sv
// Per-tag owner record for outstanding loads: combinational lookup of the
// returning tag, free on return, allocate on a granted load.
module mem_tag_owner_table
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_en,
   input  logic [TAG_W-1:0] alloc_tag,
   input  client_t          alloc_client,
   input  logic [TAG_W-1:0] lkup_tag,
   output owner_ent_t       lkup_ent,
   input  logic             free_en
);

   localparam int DEPTH = 1 << TAG_W;

   owner_ent_t entries [DEPTH];

   assign lkup_ent = entries[lkup_tag];

   // The allocate write comes last so a tag returned and re-granted in the
   // same cycle ends up owned by the new requester.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      end else begin
         if (free_en) entries[lkup_tag] <= '0;
         if (alloc_en) entries[alloc_tag] <= '{vld: 1'b1, is_dc: (alloc_client == DC)};
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the I-side and D-side memory clients onto the single memory
// port, tracks load tag ownership and steers returned data back.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int TAG_W      = 4,
   parameter int STARVE_LIM = 4
) (
   input logic clk,
   input logic rst,
   mem_bus_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   logic [CNT_W-1:0]  starve_cnt;
   logic              ic_req;
   logic              dc_req;
   logic              force_ic;
   logic              accept;
   client_t           winner;
   bus_cmd_t          cmd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ic_gnt;
   logic              dc_gnt;
   logic              alloc_en;
   logic              ret_vld;
   owner_ent_t        ret_ent;
   logic              ic_ret;
   logic              dc_ret;
   logic              free_en;
   logic              arb_err;

   // While reset is held every request and return is masked so all
   // outputs read as idle.
   assign ic_req   = bus.ic_req_vld & ~rst;
   assign dc_req   = bus.dc_req_vld & ~rst;
   assign force_ic = (starve_cnt == CNT_W'(STARVE_LIM));
   assign accept   = (bus.mem2proc_response != '0);

   always_comb begin
      winner = IC;
      cmd    = BUS_NONE;
      addr   = '0;
      wdata  = '0;
      if (dc_req && !(ic_req && force_ic)) begin
         winner = DC;
         cmd    = bus.dc_req_st ? BUS_STORE : BUS_LOAD;
         addr   = bus.dc_req_addr;
         wdata  = bus.dc_req_data;
      end else if (ic_req) begin
         winner = IC;
         cmd    = BUS_LOAD;
         addr   = bus.ic_req_addr;
      end
   end

   assign ic_gnt   = ic_req && (winner == IC) && accept;
   assign dc_gnt   = dc_req && (winner == DC) && accept;
   assign alloc_en = accept && (cmd == BUS_LOAD);

   assign bus.proc2mem_command = cmd;
   assign bus.proc2mem_addr    = addr;
   assign bus.proc2mem_data    = wdata;
   assign bus.ic_gnt           = ic_gnt;
   assign bus.dc_gnt           = dc_gnt;
   assign bus.ic_gnt_tag       = ic_gnt ? bus.mem2proc_response : '0;
   assign bus.dc_gnt_tag       = dc_gnt ? bus.mem2proc_response : '0;

   mem_tag_owner_table #(
      .TAG_W(TAG_W)
   ) u_owner (
      .clk         (clk),
      .rst         (rst),
      .alloc_en    (alloc_en),
      .alloc_tag   (bus.mem2proc_response),
      .alloc_client(winner),
      .lkup_tag    (bus.mem2proc_tag),
      .lkup_ent    (ret_ent),
      .free_en     (free_en)
   );

   assign ret_vld = ~rst && (bus.mem2proc_tag != '0);
   assign free_en = ret_vld && ret_ent.vld;
   assign ic_ret  = free_en && !ret_ent.is_dc;
   assign dc_ret  = free_en && ret_ent.is_dc;

   assign bus.ic_data_vld = ic_ret;
   assign bus.ic_data_tag = ic_ret ? bus.mem2proc_tag : '0;
   assign bus.ic_data     = ic_ret ? bus.mem2proc_data : '0;
   assign bus.dc_data_vld = dc_ret;
   assign bus.dc_data_tag = dc_ret ? bus.mem2proc_tag : '0;
   assign bus.dc_data     = dc_ret ? bus.mem2proc_data : '0;
   assign bus.arb_err     = arb_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arb_err <= 1'b0;
      end else if (ret_vld && !ret_ent.vld) begin
         arb_err <= 1'b1;
      end
   end

   // Counts consecutive cycles the I-side waited; dropping the request
   // forfeits any accumulated priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!ic_req || ic_gnt) begin
         starve_cnt <= '0;
      end else if (!force_ic) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, directed corner
// sequences and randomized traffic against a tag-ownership model.
module tb_mem_bus_arbiter;

   localparam int ADDR_W     = 64;
   localparam int DATA_W     = 64;
   localparam int TAG_W      = 4;
   localparam int STARVE_LIM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   mem_bus_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .STARVE_LIM(STARVE_LIM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: who owns each tag, how long the I-side has waited.
   bit m_vld [16];
   bit m_dc  [16];
   int m_starve;
   bit m_err;

   // Inputs of the cycle currently being driven, consumed at the clock edge.
   bit         c_ic, c_dc, c_st;
   logic [3:0] c_resp, c_rtag;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int t = 0; t < 16; t++) begin
         m_vld[t] = 1'b0;
         m_dc[t]  = 1'b0;
      end
      m_starve = 0;
      m_err    = 1'b0;
   endtask

   task automatic drive(input bit ic, input logic [63:0] ia, input bit dc, input bit st,
                        input logic [63:0] da, input logic [63:0] dd, input logic [3:0] resp,
                        input logic [3:0] rt, input logic [63:0] rd);
      bit dc_wins, ic_wins, e_ig, e_dg, e_iv, e_dv;
      logic [1:0]  e_cmd;
      logic [63:0] e_addr, e_data;
      bus.ic_req_vld        = ic;
      bus.ic_req_addr       = ia;
      bus.dc_req_vld        = dc;
      bus.dc_req_st         = st;
      bus.dc_req_addr       = da;
      bus.dc_req_data       = dd;
      bus.mem2proc_response = resp;
      bus.mem2proc_tag      = rt;
      bus.mem2proc_data     = rd;
      c_ic = ic; c_dc = dc; c_st = st; c_resp = resp; c_rtag = rt;
      #1;
      // D-side has priority unless the I-side has already waited its limit.
      if (ic && dc) dc_wins = (m_starve < STARVE_LIM);
      else          dc_wins = dc;
      ic_wins = ic && !dc_wins;
      e_ig = ic_wins && (resp != 0);
      e_dg = dc_wins && (resp != 0);
      e_cmd  = dc_wins ? (st ? 2'd2 : 2'd1) : (ic_wins ? 2'd1 : 2'd0);
      e_addr = dc_wins ? da : (ic_wins ? ia : 64'd0);
      e_data = dc_wins ? dd : 64'd0;
      e_iv = (rt != 0) && m_vld[rt] && !m_dc[rt];
      e_dv = (rt != 0) && m_vld[rt] && m_dc[rt];
      chk("m_ic_gnt", bus.ic_gnt, e_ig);
      chk("m_dc_gnt", bus.dc_gnt, e_dg);
      chk("m_ic_gnt_tag", bus.ic_gnt_tag, e_ig ? resp : 4'd0);
      chk("m_dc_gnt_tag", bus.dc_gnt_tag, e_dg ? resp : 4'd0);
      chk("m_cmd", bus.proc2mem_command, e_cmd);
      chk("m_addr", bus.proc2mem_addr, e_addr);
      chk("m_wdata", bus.proc2mem_data, e_data);
      chk("m_ic_data_vld", bus.ic_data_vld, e_iv);
      chk("m_dc_data_vld", bus.dc_data_vld, e_dv);
      chk("m_ic_data", bus.ic_data, e_iv ? rd : 64'd0);
      chk("m_dc_data", bus.dc_data, e_dv ? rd : 64'd0);
      chk("m_ic_data_tag", bus.ic_data_tag, e_iv ? rt : 4'd0);
      chk("m_dc_data_tag", bus.dc_data_tag, e_dv ? rt : 4'd0);
      chk("m_arb_err", bus.arb_err, m_err);
   endtask

   task automatic tick();
      bit ig, dc_wins;
      @(posedge clk);
      if (c_ic && c_dc) dc_wins = (m_starve < STARVE_LIM);
      else              dc_wins = c_dc;
      ig = c_ic && !dc_wins && (c_resp != 0);
      if (c_rtag != 0) begin
         if (m_vld[c_rtag]) m_vld[c_rtag] = 1'b0;
         else               m_err = 1'b1;
      end
      if (c_resp != 0 && (c_ic || c_dc) && !(dc_wins && c_st)) begin
         m_vld[c_resp] = 1'b1;
         m_dc[c_resp]  = dc_wins;
      end
      if (c_ic && !ig) m_starve = (m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM;
      else             m_starve = 0;
      @(negedge clk);
   endtask

   task automatic idle(input logic [3:0] rt = 4'd0, input logic [63:0] rd = 64'd0);
      drive(0, 64'd0, 0, 0, 64'd0, 64'd0, 4'd0, rt, rd);
      tick();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.ic_req_vld = 1'b1; bus.ic_req_addr = 64'h55;
      bus.dc_req_vld = 1'b1; bus.dc_req_st = 1'b0; bus.dc_req_addr = 64'h66;
      bus.dc_req_data = 64'h77;
      bus.mem2proc_response = 4'd5; bus.mem2proc_tag = 4'd6; bus.mem2proc_data = 64'h88;
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("rst_ic_gnt", bus.ic_gnt, 0);
         chk("rst_dc_gnt", bus.dc_gnt, 0);
         chk("rst_cmd", bus.proc2mem_command, 0);
         chk("rst_addr", bus.proc2mem_addr, 0);
         chk("rst_ic_data_vld", bus.ic_data_vld, 0);
         chk("rst_dc_data_vld", bus.dc_data_vld, 0);
         chk("rst_arb_err", bus.arb_err, 0);
         @(negedge clk);
      end
      bus.ic_req_vld = 1'b0; bus.dc_req_vld = 1'b0;
      bus.mem2proc_response = 4'd0; bus.mem2proc_tag = 4'd0;
      rst = 1'b0;
      model_clear();
   endtask

   typedef struct {
      bit         ic, dc, st;
      logic [3:0] resp;
      logic [1:0] cmd;
      bit         ig, dg;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{ic:0, dc:0, st:0, resp:4'd5, cmd:2'd0, ig:0, dg:0};
      vecs[1] = '{ic:1, dc:0, st:0, resp:4'd3, cmd:2'd1, ig:1, dg:0};
      vecs[2] = '{ic:0, dc:1, st:0, resp:4'd5, cmd:2'd1, ig:0, dg:1};
      vecs[3] = '{ic:0, dc:1, st:1, resp:4'd7, cmd:2'd2, ig:0, dg:1};
      vecs[4] = '{ic:1, dc:1, st:0, resp:4'd5, cmd:2'd1, ig:0, dg:1};
      vecs[5] = '{ic:1, dc:1, st:1, resp:4'd0, cmd:2'd2, ig:0, dg:0};
      vecs[6] = '{ic:1, dc:0, st:0, resp:4'd0, cmd:2'd1, ig:0, dg:0};
      vecs[7] = '{ic:0, dc:0, st:0, resp:4'd0, cmd:2'd0, ig:0, dg:0};
      model_clear();
      do_reset();

      // Single-cycle arbitration vectors.
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].ic, 64'h1000 + i, vecs[i].dc, vecs[i].st, 64'h2000 + i, 64'h3000 + i,
               vecs[i].resp, 4'd0, 64'd0);
         chk("vec_ic_gnt", bus.ic_gnt, vecs[i].ig);
         chk("vec_dc_gnt", bus.dc_gnt, vecs[i].dg);
         chk("vec_cmd", bus.proc2mem_command, vecs[i].cmd);
         tick();
         idle();
      end

      // I-side load, tag 3, data returned later.
      do_reset();
      drive(1, 64'h100, 0, 0, 64'd0, 64'd0, 4'd3, 4'd0, 64'd0);
      chk("ic_load_gnt", bus.ic_gnt, 1);
      chk("ic_load_tag", bus.ic_gnt_tag, 3);
      chk("ic_load_addr", bus.proc2mem_addr, 64'h100);
      tick();
      repeat (3) idle();
      drive(0, 64'd0, 0, 0, 64'd0, 64'd0, 4'd0, 4'd3, 64'hDEAD);
      chk("ic_ret_vld", bus.ic_data_vld, 1);
      chk("ic_ret_data", bus.ic_data, 64'hDEAD);
      chk("ic_ret_dc_vld", bus.dc_data_vld, 0);
      tick();

      // Starvation: four D-side wins, then the I-side is forced through.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1, 64'h400, 1, 1, 64'h500, 64'h9, 4'(k + 1), 4'd0, 64'd0);
         chk("starve_dc_gnt", bus.dc_gnt, 1);
         chk("starve_ic_gnt", bus.ic_gnt, 0);
         tick();
      end
      drive(1, 64'h400, 1, 1, 64'h500, 64'h9, 4'd9, 4'd0, 64'd0);
      chk("starve_force_ic", bus.ic_gnt, 1);
      chk("starve_force_dc", bus.dc_gnt, 0);
      chk("starve_force_addr", bus.proc2mem_addr, 64'h400);
      tick();
      drive(1, 64'h400, 1, 1, 64'h500, 64'h9, 4'd10, 4'd0, 64'd0);
      chk("starve_cleared", bus.dc_gnt, 1);
      tick();
      idle();

      // D-side store gets no owner entry; a return on its tag is an error.
      do_reset();
      drive(0, 64'd0, 1, 1, 64'h600, 64'hBEEF, 4'd7, 4'd0, 64'd0);
      chk("st_gnt", bus.dc_gnt, 1);
      chk("st_cmd", bus.proc2mem_command, 2);
      chk("st_data", bus.proc2mem_data, 64'hBEEF);
      tick();
      drive(0, 64'd0, 0, 0, 64'd0, 64'd0, 4'd0, 4'd7, 64'h1);
      chk("st_ret_ic", bus.ic_data_vld, 0);
      chk("st_ret_dc", bus.dc_data_vld, 0);
      tick();
      #1;
      chk("st_arb_err", bus.arb_err, 1);

      // Memory rejects three times, then accepts with tag 2.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(0, 64'd0, 1, 0, 64'h200, 64'd0, 4'd0, 4'd0, 64'd0);
         chk("rej_dc_gnt", bus.dc_gnt, 0);
         tick();
      end
      drive(0, 64'd0, 1, 0, 64'h200, 64'd0, 4'd2, 4'd0, 64'd0);
      chk("rej_then_gnt", bus.dc_gnt, 1);
      chk("rej_then_tag", bus.dc_gnt_tag, 2);
      tick();
      drive(0, 64'd0, 0, 0, 64'd0, 64'd0, 4'd0, 4'd2, 64'h22);
      chk("rej_ret_dc", bus.dc_data_vld, 1);
      tick();

      // Tag 4 returned to the I-side while being re-granted to the D-side.
      do_reset();
      drive(1, 64'h40, 0, 0, 64'd0, 64'd0, 4'd4, 4'd0, 64'd0);
      tick();
      drive(0, 64'd0, 1, 0, 64'h80, 64'd0, 4'd4, 4'd4, 64'hAB);
      chk("same_tag_ic_vld", bus.ic_data_vld, 1);
      chk("same_tag_dc_gnt", bus.dc_gnt, 1);
      chk("same_tag_dc_vld", bus.dc_data_vld, 0);
      tick();
      idle(4'd4, 64'hCD);
      drive(0, 64'd0, 0, 0, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
      tick();

      // Reset with tag 6 outstanding: the later return is unowned.
      do_reset();
      drive(0, 64'd0, 1, 0, 64'h600, 64'd0, 4'd6, 4'd0, 64'd0);
      tick();
      do_reset();
      drive(0, 64'd0, 0, 0, 64'd0, 64'd0, 4'd0, 4'd6, 64'h66);
      chk("post_rst_ic_vld", bus.ic_data_vld, 0);
      chk("post_rst_dc_vld", bus.dc_data_vld, 0);
      tick();
      #1;
      chk("post_rst_err", bus.arb_err, 1);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 400; n++) begin
         int         owned[$];
         logic [3:0] resp, rt;
         int         r;
         for (int t = 1; t < 16; t++) if (m_vld[t]) owned.push_back(t);
         resp = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
         r = int'($urandom_range(99));
         if (r < 60 && owned.size() > 0) rt = 4'(owned[$urandom_range(owned.size() - 1)]);
         else if (r < 70)                rt = 4'($urandom_range(15, 1));
         else                            rt = 4'd0;
         drive(1'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom}, resp, rt, {$urandom, $urandom});
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
